uart_frame_parser: RTL and testbench

UART_FRAME_PARSER -- requirements
Module: uart_frame_parser

---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_frame_buf.sv | 43 ++++
 rtl/uart_frame_parser.sv | 142 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART frame parser.
// The CHK state exists only when UART_FRAME_CHECKSUM_EN is defined.
package uart_frame_pkg;

   localparam logic [7:0] SOF      = 8'hAA;
   localparam logic [1:0] ERR_NONE = 2'd0;
   localparam logic [1:0] ERR_LEN  = 2'd1;
   localparam logic [1:0] ERR_CHK  = 2'd2;
   localparam logic [1:0] ERR_OVR  = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LEN     = 3'd1,
      ST_PAYLOAD = 3'd2,
`ifdef UART_FRAME_CHECKSUM_EN
      ST_CHK     = 3'd3,
`endif
      ST_DRAIN   = 3'd4
   } state_e;

   function automatic logic len_legal(input logic [7:0] len, input int max_len);
      return (len != 8'd0) && (int'(len) <= max_len);
   endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: MAX_LEN x 8 memory with write/read pointers.
// Storage is not reset; pointers are, and the parser gates the read data.
module uart_frame_buf #(
   parameter int MAX_LEN = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       clr_i,
   input  logic       wr_en_i,
   input  logic [7:0] wr_data_i,
   input  logic       rd_adv_i,
   output logic [7:0] wr_ptr_o,
   output logic [7:0] rd_ptr_o,
   output logic [7:0] rd_data_o
);

   localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

   logic [7:0] mem [MAX_LEN];
   logic [7:0] wr_ptr_q, rd_ptr_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem[wr_ptr_q[PW-1:0]] <= wr_data_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= 8'd0;
         rd_ptr_q <= 8'd0;
      end else if (clr_i) begin
         wr_ptr_q <= 8'd0;
         rd_ptr_q <= 8'd0;
      end else begin
         if (wr_en_i)  wr_ptr_q <= wr_ptr_q + 8'd1;
         if (rd_adv_i) rd_ptr_q <= rd_ptr_q + 8'd1;
      end
   end

   assign wr_ptr_o  = wr_ptr_q;
   assign rd_ptr_o  = rd_ptr_q;
   assign rd_data_o = mem[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/LEN/payload[/CHK] frames from a UART byte stream and drains the
// payload over a valid/ready port. Define UART_FRAME_CHECKSUM_EN for the CHK byte.
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int MAX_LEN = 16
) (
   input  logic       UART_clk,
   input  logic       rst,
   input  logic [7:0] rx_byte,
   input  logic       rx_en,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code
);

   state_e     state_q;
   logic [7:0] len_q;
`ifdef UART_FRAME_CHECKSUM_EN
   logic [7:0] xor_q;
`endif
   logic       out_valid_q, out_last_q, frame_ok_q, frame_err_q;
   logic [1:0] err_code_q;

   logic       buf_clr, buf_wr, buf_adv;
   logic [7:0] buf_wr_ptr, buf_rd_ptr, buf_rd_data;

   assign buf_clr = rx_en && (state_q == ST_LEN);
   assign buf_wr  = rx_en && (state_q == ST_PAYLOAD);
   assign buf_adv = (state_q == ST_DRAIN) && out_valid_q && out_ready;

   uart_frame_buf #(.MAX_LEN(MAX_LEN)) u_buf (
      .clk_i     (UART_clk),
      .rst_ni    (rst),
      .clr_i     (buf_clr),
      .wr_en_i   (buf_wr),
      .wr_data_i (rx_byte),
      .rd_adv_i  (buf_adv),
      .wr_ptr_o  (buf_wr_ptr),
      .rd_ptr_o  (buf_rd_ptr),
      .rd_data_o (buf_rd_data)
   );

   always_ff @(posedge UART_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         len_q       <= 8'd0;
`ifdef UART_FRAME_CHECKSUM_EN
         xor_q       <= 8'd0;
`endif
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         err_code_q  <= ERR_NONE;
      end else begin
         frame_ok_q  <= 1'b0;
         frame_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (rx_en && rx_byte == SOF) state_q <= ST_LEN;
            end
            ST_LEN: begin
               if (rx_en) begin
                  if (!len_legal(rx_byte, MAX_LEN)) begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= ERR_LEN;
                     state_q     <= ST_IDLE;
                  end else begin
                     len_q   <= rx_byte;
`ifdef UART_FRAME_CHECKSUM_EN
                     xor_q   <= rx_byte;
`endif
                     state_q <= ST_PAYLOAD;
                  end
               end
            end
            ST_PAYLOAD: begin
               if (rx_en) begin
`ifdef UART_FRAME_CHECKSUM_EN
                  xor_q <= xor_q ^ rx_byte;
                  if (buf_wr_ptr == len_q - 8'd1) state_q <= ST_CHK;
`else
                  if (buf_wr_ptr == len_q - 8'd1) begin
                     state_q     <= ST_DRAIN;
                     frame_ok_q  <= 1'b1;
                     out_valid_q <= 1'b1;
                     out_last_q  <= (len_q == 8'd1);
                  end
`endif
               end
            end
`ifdef UART_FRAME_CHECKSUM_EN
            ST_CHK: begin
               if (rx_en) begin
                  if (rx_byte == xor_q) begin
                     state_q     <= ST_DRAIN;
                     frame_ok_q  <= 1'b1;
                     out_valid_q <= 1'b1;
                     out_last_q  <= (len_q == 8'd1);
                  end else begin
                     frame_err_q <= 1'b1;
                     err_code_q  <= ERR_CHK;
                     state_q     <= ST_IDLE;
                  end
               end
            end
`endif
            ST_DRAIN: begin
               // Bytes arriving while draining are lost; flag them but keep draining.
               if (rx_en) begin
                  frame_err_q <= 1'b1;
                  err_code_q  <= ERR_OVR;
               end
               if (out_valid_q && out_ready) begin
                  if (out_last_q) begin
                     out_valid_q <= 1'b0;
                     out_last_q  <= 1'b0;
                     state_q     <= ST_IDLE;
                  end else begin
                     out_last_q <= (buf_rd_ptr + 8'd2 == len_q);
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Read data is masked so stale buffer contents never reach the port.
   assign out_data  = out_valid_q ? buf_rd_data : 8'h00;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign frame_ok  = frame_ok_q;
   assign frame_err = frame_err_q;
   assign err_code  = err_code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed scenarios plus randomized
// frames checked against a frame-level reference model.
module tb_uart_frame_parser;

   localparam int MAX_LEN = 16;
`ifdef UART_FRAME_CHECKSUM_EN
   localparam bit CK = 1'b1;
`else
   localparam bit CK = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       rx_en = 1'b0;
   logic [7:0] rx_byte = 8'h00;
   logic       out_ready;
   logic       out_valid, out_last, frame_ok, frame_err;
   logic [7:0] out_data;
   logic [1:0] err_code;

   int checks = 0;
   int errors = 0;

   bit rand_ready = 1'b0;
   bit ready_fix  = 1'b1;
   bit rnd_bit    = 1'b1;

   logic [8:0] got_q[$];
   int         ok_cnt = 0;
   int         err_cnt = 0;
   logic [1:0] last_err = 2'b00;

   uart_frame_parser #(.MAX_LEN(MAX_LEN)) dut (
      .UART_clk  (clk),
      .rst       (rst),
      .rx_byte   (rx_byte),
      .rx_en     (rx_en),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_last  (out_last),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   always_comb out_ready = rand_ready ? rnd_bit : ready_fix;

   always @(posedge clk) begin
      #1;
      rnd_bit = ($urandom % 3) != 0;
   end

   // Observe handshakes and pulses mid-cycle, where everything is settled.
   always @(negedge clk) begin
      if (out_valid && out_ready) got_q.push_back({out_last, out_data});
      if (frame_ok) ok_cnt++;
      if (frame_err) begin
         err_cnt++;
         last_err = err_code;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: frame outcome from length legality and checksum validity.
   function automatic logic [7:0] chk_of(input logic [7:0] len, input logic [7:0] pl[$]);
      logic [7:0] c = len;
      foreach (pl[i]) c = c ^ pl[i];
      return c;
   endfunction

   function automatic int outcome(input int len, input bit chk_ok);
      if (len == 0 || len > MAX_LEN) return 1;
      if (CK && !chk_ok) return 2;
      return 0;
   endfunction

   task automatic send(input logic [7:0] b);
      rx_byte = b;
      rx_en   = 1'b1;
      @(posedge clk); #1;
      rx_en   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset;
      idle(2);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last got %0b exp 0", out_last); end
      checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL rst_ok got %0b exp 0", frame_ok); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", frame_err); end
      checks++; if (err_code !== 2'b00) begin errors++; $display("FAIL rst_code got %0d exp 0", err_code); end
      checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got %h exp 00", out_data); end
      rst = 1'b1;
      idle(2);
   endtask

   task automatic test_good_frame;
      ready_fix = 1'b1;
      got_q.delete();
      send(8'hAA); send(8'h03); send(8'h11); send(8'h22); send(8'h33);
`ifdef UART_FRAME_CHECKSUM_EN
      send(8'h03);
`endif
      checks++; if (frame_ok !== 1'b1) begin errors++; $display("FAIL good_ok got %0b exp 1", frame_ok); end
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL good_valid got %0b exp 1", out_valid); end
      checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL good_d0 got %h exp 11", out_data); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL good_last0 got %0b exp 0", out_last); end
      idle(1);
      checks++; if (frame_ok !== 1'b0) begin errors++; $display("FAIL good_okpulse got %0b exp 0", frame_ok); end
      checks++; if (out_data !== 8'h22 || out_last !== 1'b0) begin errors++; $display("FAIL good_d1 got %h/%0b exp 22/0", out_data, out_last); end
      idle(1);
      checks++; if (out_data !== 8'h33 || out_last !== 1'b1) begin errors++; $display("FAIL good_d2 got %h/%0b exp 33/1", out_data, out_last); end
      idle(1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL good_end got %0b exp 0", out_valid); end
   endtask

`ifdef UART_FRAME_CHECKSUM_EN
   task automatic test_bad_chk;
      int e0;
      e0 = err_cnt;
      got_q.delete();
      send(8'hAA); send(8'h02); send(8'h10); send(8'h20); send(8'h00);
      checks++; if (frame_err !== 1'b1 || err_code !== 2'd2) begin errors++; $display("FAIL badchk_err got %0b/%0d exp 1/2", frame_err, err_code); end
      idle(4);
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL badchk_out got %0d bytes exp 0", got_q.size()); end
      checks++; if (err_cnt - e0 != 1) begin errors++; $display("FAIL badchk_cnt got %0d exp 1", err_cnt - e0); end
   endtask
`endif

   task automatic test_bad_len;
      int e0;
      e0 = err_cnt;
      got_q.delete();
      send(8'hAA); send(8'h00);
      checks++; if (frame_err !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL badlen0 got %0b/%0d exp 1/1", frame_err, err_code); end
      send(8'hAA); send(8'h11);
      checks++; if (frame_err !== 1'b1 || err_code !== 2'd1) begin errors++; $display("FAIL badlen17 got %0b/%0d exp 1/1", frame_err, err_code); end
      idle(1);
      checks++; if (err_cnt - e0 != 2) begin errors++; $display("FAIL badlen_cnt got %0d exp 2", err_cnt - e0); end
      send(8'hAA); send(8'h01); send(8'h5A);
`ifdef UART_FRAME_CHECKSUM_EN
      send(8'h5B);
`endif
      checks++; if (frame_ok !== 1'b1 || out_data !== 8'h5A || out_last !== 1'b1) begin errors++; $display("FAIL badlen_next got %0b/%h/%0b exp 1/5a/1", frame_ok, out_data, out_last); end
      idle(1);
      checks++; if (out_valid !== 1'b0 || got_q.size() != 1) begin errors++; $display("FAIL badlen_done got %0b/%0d exp 0/1", out_valid, got_q.size()); end
   endtask

   task automatic test_backpressure;
      ready_fix = 1'b0;
      got_q.delete();
      send(8'hAA); send(8'h02); send(8'hC3); send(8'h3C);
`ifdef UART_FRAME_CHECKSUM_EN
      send(8'hFD);
`endif
      for (int i = 0; i < 5; i++) begin
         if (i == 2) send(8'h55);
         else idle(1);
         checks++; if (out_valid !== 1'b1 || out_data !== 8'hC3) begin errors++; $display("FAIL bp_hold%0d got %0b/%h exp 1/c3", i, out_valid, out_data); end
         if (i == 2) begin
            checks++; if (frame_err !== 1'b1 || err_code !== 2'd3) begin errors++; $display("FAIL bp_ovr got %0b/%0d exp 1/3", frame_err, err_code); end
         end
      end
      ready_fix = 1'b1;
      idle(1);
      checks++; if (out_data !== 8'h3C || out_last !== 1'b1) begin errors++; $display("FAIL bp_d1 got %h/%0b exp 3c/1", out_data, out_last); end
      idle(1);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end got %0b exp 0", out_valid); end
      checks++; if (got_q.size() != 2) begin errors++; $display("FAIL bp_count got %0d exp 2", got_q.size()); end
      else begin
         checks++; if (got_q[0] !== 9'h0C3 || got_q[1] !== 9'h13C) begin errors++; $display("FAIL bp_bytes got %h %h exp 0c3 13c", got_q[0], got_q[1]); end
      end
   endtask

   task automatic test_reset_mid;
      send(8'hAA); send(8'h04); send(8'h11);
      rst = 1'b0; #1;
      checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rmid_vl got %0b/%0b exp 0/0", out_valid, out_last); end
      checks++; if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin errors++; $display("FAIL rmid_pulse got %0b/%0b exp 0/0", frame_ok, frame_err); end
      checks++; if (err_code !== 2'b00 || out_data !== 8'h00) begin errors++; $display("FAIL rmid_code got %0d/%h exp 0/00", err_code, out_data); end
      idle(1);
      rst = 1'b1;
      idle(1);
      got_q.delete();
      send(8'hAA); send(8'h01); send(8'h7E);
`ifdef UART_FRAME_CHECKSUM_EN
      send(8'h7F);
`endif
      checks++; if (frame_ok !== 1'b1 || out_data !== 8'h7E || out_last !== 1'b1) begin errors++; $display("FAIL rmid_next got %0b/%h/%0b exp 1/7e/1", frame_ok, out_data, out_last); end
      idle(2);
      // Reset in the middle of a drain must not leave stale bytes visible.
      ready_fix = 1'b0;
      send(8'hAA); send(8'h02); send(8'hA1); send(8'hA2);
`ifdef UART_FRAME_CHECKSUM_EN
      send(8'h01);
`endif
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rdrain_pre got %0b exp 1", out_valid); end
      rst = 1'b0; #1;
      checks++; if (out_valid !== 1'b0 || out_data !== 8'h00) begin errors++; $display("FAIL rdrain_rst got %0b/%h exp 0/00", out_valid, out_data); end
      idle(1);
      rst = 1'b1;
      ready_fix = 1'b1;
      idle(3);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rdrain_post got %0b exp 0", out_valid); end
   endtask

   task automatic test_random;
      logic [8:0] exp_q[$];
      logic [7:0] pl[$];
      logic [7:0] b, c;
      int len, code, ok0, err0, exp_ok, exp_err, t;
      bit chk_ok;
      got_q.delete();
      ok0 = ok_cnt; err0 = err_cnt; exp_ok = 0; exp_err = 0;
      rand_ready = 1'b1;
      for (int f = 0; f < 40; f++) begin
         repeat ($urandom_range(0, 2)) begin
            b = 8'($urandom);
            if (b == 8'hAA) b = 8'h55;
            send(b);
         end
         len = $urandom_range(0, MAX_LEN + 3);
         pl.delete();
         chk_ok = 1'b1;
         send(8'hAA);
         send(8'(len));
         if (len >= 1 && len <= MAX_LEN) begin
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            foreach (pl[i]) begin
               send(pl[i]);
               idle($urandom_range(0, 1));
            end
            chk_ok = ($urandom % 4) != 0;
            c = chk_of(8'(len), pl);
            if (!chk_ok) c = c ^ 8'($urandom_range(1, 255));
            if (CK) send(c);
         end
         code = outcome(len, chk_ok);
         if (code == 0) begin
            exp_ok++;
            foreach (pl[i]) exp_q.push_back({(i == len - 1), pl[i]});
            t = 0;
            while (got_q.size() < exp_q.size() && t < 400) begin
               @(posedge clk); t++;
            end
            #1;
            checks++; if (t >= 400) begin errors++; $display("FAIL rnd_drain_timeout frame %0d got %0d exp %0d bytes", f, got_q.size(), exp_q.size()); end
         end else begin
            exp_err++;
            idle(1);
            checks++; if (last_err !== 2'(code)) begin errors++; $display("FAIL rnd_code frame %0d got %0d exp %0d", f, last_err, code); end
         end
         idle(1);
      end
      rand_ready = 1'b0;
      idle(2);
      checks++; if (ok_cnt - ok0 != exp_ok) begin errors++; $display("FAIL rnd_ok_cnt got %0d exp %0d", ok_cnt - ok0, exp_ok); end
      checks++; if (err_cnt - err0 != exp_err) begin errors++; $display("FAIL rnd_err_cnt got %0d exp %0d", err_cnt - err0, exp_err); end
      checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL rnd_bytes got %0d exp %0d", got_q.size(), exp_q.size()); end
      else begin
         foreach (exp_q[i]) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL rnd_byte%0d got %h exp %h", i, got_q[i], exp_q[i]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
`ifdef UART_FRAME_CHECKSUM_EN
      test_bad_chk();
`endif
      test_bad_len();
      test_backpressure();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
